// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: walks a PC through a combinational instruction
// memory and hands one registered instruction at a time to decode.
module instruction_fetch_ctrl #(
  parameter int          ROW_I       = 16,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] pc,
  input  logic [15:0] imem_instr,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  // Byte span of the memory; the mask keeps pc halfword-aligned and in range.
  localparam logic [16:0] SPAN    = 17'(2 * ROW_I);
  localparam logic [15:0] PC_MASK = 16'((SPAN - 17'd1) & 17'h1FFFE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] instr_reg, instr_next;
  logic [15:0] instr_pc_reg, instr_pc_next;
  logic        valid_reg, valid_next;
  logic        holding_halt;

  assign holding_halt = valid_reg && (instr_reg[15:12] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= 16'h0000;
      instr_pc_reg <= 16'h0000;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (redirect) begin
          pc_next    = redirect_pc & PC_MASK;
          state_next = FETCH;
        end else if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          // Flush wins over a stall and cancels any pending halt.
          pc_next    = redirect_pc & PC_MASK;
          valid_next = 1'b0;
        end else if (holding_halt) begin
          // No more captures once a halt is pending; stop when decode takes it.
          if (instr_ready) begin
            state_next = HALTED;
            valid_next = 1'b0;
          end
        end else if (!valid_reg || instr_ready) begin
          instr_next    = imem_instr;
          instr_pc_next = pc_reg;
          valid_next    = 1'b1;
          pc_next       = (pc_reg + 16'd2) & PC_MASK;
        end
      end
      HALTED: begin
        valid_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == HALTED);

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl with a 16-word memory holding 0x1000+i.
module tb_instruction_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pc;
  logic [15:0] imem_instr;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mem [16];
  logic [15:0] logq [$];

  instruction_fetch_ctrl #(
    .ROW_I(16), .RESET_PC(16'h0000), .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .imem_instr(imem_instr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[pc[4:1]];

  // Record every instruction that decode actually accepts.
  always @(posedge clk)
    if (!rst && instr_valid && instr_ready) logq.push_back(instr);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_instr(input logic [15:0] want);
    int i;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (instr_valid && instr === want) break;
    end
    n_cmp++;
    if (i == 64) begin
      n_fail++;
      $display("FAIL wait_instr: %h never appeared (last instr=%h valid=%b)", want, instr, instr_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({instr_valid, instr, instr_pc, pc, halted} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b instr=%h ipc=%h pc=%h halted=%b, want all zero",
               instr_valid, instr, instr_pc, pc, halted);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, pc} !== {1'b0, 16'h0}) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got v=%b pc=%h, want v=0 pc=0000", k, instr_valid, pc);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [15:0] e_instr, e_ipc, e_pc;
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);  // start while fetching must be ignored
      @(negedge clk);
      e_instr = 16'h1000 + 16'(k % 16);
      e_ipc   = 16'((2 * k) % 32);
      e_pc    = 16'((2 * (k + 1)) % 32);
      n_cmp++;
      if ({instr_valid, instr, instr_pc, pc} !== {1'b1, e_instr, e_ipc, e_pc}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b instr=%h ipc=%h pc=%h, want v=1 instr=%h ipc=%h pc=%h",
                 k, instr_valid, instr, instr_pc, pc, e_instr, e_ipc, e_pc);
      end
    end
    start = 1'b0;
    $display("test_stream done");
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    wait_instr(16'h1003);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 16'h1003, 16'h0006, 16'h0008}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b instr=%h ipc=%h pc=%h, want v=1 instr=1003 ipc=0006 pc=0008",
                 k, instr_valid, instr, instr_pc, pc);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h1004, 16'h0008}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b instr=%h ipc=%h, want v=1 instr=1004 ipc=0008",
               instr_valid, instr, instr_pc);
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect();
    do_reset();
    logq.delete();
    instr_ready = 1'b1;
    pulse_start();
    wait_instr(16'h1002);
    instr_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'hFF15;  // upper bits and bit 0 must be masked to 0x14
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++;
    if ({instr_valid, pc} !== {1'b0, 16'h0014}) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%b pc=%h, want v=0 pc=0014", instr_valid, pc);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h100A, 16'h0014}) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%b instr=%h ipc=%h, want v=1 instr=100A ipc=0014",
               instr_valid, instr, instr_pc);
    end
    @(negedge clk);
    n_cmp++;
    if ((logq.size() < 3) || ({logq[0], logq[1], logq[2]} !== {16'h1000, 16'h1001, 16'h100A})) begin
      n_fail++;
      $display("FAIL redirect_log: got %0d transfers first=%p, want 1000 1001 100A", logq.size(), logq);
    end
    $display("test_redirect done");
  endtask

  task automatic test_halt();
    int cyc;
    mem[5] = 16'hF000;
    do_reset();
    logq.delete();
    instr_ready = 1'b1;
    pulse_start();
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (halted) break;
    end
    n_cmp++;
    if (cyc == 30) begin
      n_fail++;
      $display("FAIL halt_reach: halted never set, got halted=%b want 1", halted);
    end
    n_cmp++;
    if ((logq.size() != 6) || ({logq[0], logq[1], logq[2], logq[3], logq[4], logq[5]} !==
        {16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'hF000})) begin
      n_fail++;
      $display("FAIL halt_log: got %0d transfers %p, want 1000..1004 F000", logq.size(), logq);
    end
    start = 1'b1; redirect = 1'b1; redirect_pc = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instr_ready = k[0];
      n_cmp++;
      if ({halted, instr_valid, pc} !== {1'b1, 1'b0, 16'h000C}) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got halted=%b v=%b pc=%h, want halted=1 v=0 pc=000C",
                 k, halted, instr_valid, pc);
      end
    end
    start = 1'b0; redirect = 1'b0;
    do_reset();
    n_cmp++;
    if ({halted, instr_valid, pc} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL halt_exit: got halted=%b v=%b pc=%h, want halted=0 v=0 pc=0000", halted, instr_valid, pc);
    end
    mem[5] = 16'h1005;
    $display("test_halt done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    wait_instr(16'h1003);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({instr_valid, instr, instr_pc, pc, halted} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b instr=%h ipc=%h pc=%h halted=%b, want all zero",
               instr_valid, instr, instr_pc, pc, halted);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, pc} !== {1'b0, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got v=%b pc=%h, want v=0 pc=0000", k, instr_valid, pc);
      end
    end
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 16'h1000, 16'h0000, 16'h0002}) begin
      n_fail++;
      $display("FAIL reset_restart: got v=%b instr=%h ipc=%h pc=%h, want v=1 instr=1000 ipc=0000 pc=0002",
               instr_valid, instr, instr_pc, pc);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
